uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive-side byte buffer that sits directly downstream of the UART receiver. It accepts received bytes over an AXI4-Stream slave port and holds them in a first-word-fall-through ring buffer for the CPU-side register interface. It captures the receiver's one-cycle overrun and frame error pulses as sticky status flags. It produces an occupancy count and an interrupt request.

## Interface
- DATA_WIDTH, 8, byte width; must match the receiver.
- ADDR_WIDTH, 4, log2 of depth; DEPTH = 2**ADDR_WIDTH entries (16).
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- input_axis_tdata  input  DATA_WIDTH  byte from the receiver.
- input_axis_tvalid  input  1  byte valid.
- input_axis_tready  output  1  FIFO can accept a byte; equals !full.
- output_axis_tdata  output  DATA_WIDTH  oldest stored byte (mem[rd_ptr]).
- output_axis_tvalid  output  1  FIFO non-empty.
- output_axis_tready  input  1  consumer pops the head byte.
- rx_overrun_error  input  1  one-cycle pulse from the receiver.
- rx_frame_error  input  1  one-cycle pulse from the receiver.
- flush  input  1  synchronous empty request.
- status_clear  input  1  clears the sticky flags.
- threshold  input  ADDR_WIDTH+1  irq level; used only with the macro.
- count  output  ADDR_WIDTH+1  occupancy, 0..DEPTH.
- overrun_flag  output  1  sticky overrun.
- frame_flag  output  1  sticky frame error.
- irq  output  1  registered interrupt request.

## Operation
- Storage and pointers:
  - DEPTH x DATA_WIDTH array.
  - wr_ptr and rd_ptr are ADDR_WIDTH+1 bits wide. The array is indexed by the low ADDR_WIDTH bits; the MSB distinguishes full from empty.
  - empty = (wr_ptr == rd_ptr).
  - full = (low bits equal) && (MSBs differ).
- Push = input_axis_tvalid && !full. A push writes mem[wr_ptr] and increments wr_ptr.
- Pop = output_axis_tvalid && output_axis_tready. A pop increments rd_ptr.
- Pointers wrap naturally at 2*DEPTH with no explicit compare.
- count = wr_ptr - rd_ptr, computed modulo 2**(ADDR_WIDTH+1).
- Push and pop in the same cycle:
  - both take effect and count is unchanged;
  - at full, push is blocked by tready = 0 and the pop proceeds;
  - at empty, pop is impossible because tvalid = 0.
- Flush:
  - sets both pointers to 0 on the next edge;
  - any simultaneous push or pop is discarded;
  - sticky flags are unaffected.
- Sticky flags:
  - overrun_flag sets on rx_overrun_error; frame_flag sets on rx_frame_error.
  - Both clear on status_clear.
  - If set and clear occur in the same cycle, set wins.
- irq is registered: irq <= overrun_flag_next || frame_flag_next || data_term. data_term is defined under Configuration.

## Timing
- Reset values:
  - both pointers 0;
  - count 0;
  - output_axis_tvalid 0;
  - input_axis_tready 1;
  - both flags 0;
  - irq 0.
  - Array contents are not reset.
- Write-to-read latency: a byte pushed at edge N appears on output_axis_tdata with tvalid high after edge N; consumable in cycle N+1.
- input_axis_tready, output_axis_tvalid, output_axis_tdata and count are combinational from registered pointers. There is no combinational path from any input to any output.
- An error pulse in cycle N sets its flag after edge N. irq follows after the same edge.
- Reset asserted mid-operation immediately empties the FIFO and clears all outputs asynchronously.

## Configuration
- UART_RX_FIFO_THRESH_EN:
  - Defined: data_term = (count_next >= threshold) && (threshold != 0).
  - Not defined: data_term = !empty_next, and the threshold port is ignored.
  - The port list is identical in both builds.

## Structure
- Shared package uart_pkg holds:
  - UART_DATA_WIDTH default (8);
  - status bit indices (overrun = 0, frame = 1) used by the register interface.
- One sub-module, uart_rx_fifo_ram:
  - simple dual-port array;
  - synchronous write;
  - asynchronous read (FWFT head);
  - parameterised by DATA_WIDTH and ADDR_WIDTH.
- Pointer, count, flag and irq logic lives in the top module.

## Test plan
- Reset, then push 0x41, 0x42, 0x43 with output_axis_tready = 0 -> count = 3; head = 0x41; tvalid = 1; tready = 1.
- Push 16 bytes 0x00..0x0F -> count = 16; input_axis_tready = 0. A 17th byte 0xFF is held off. Pop one byte -> 0x00 is returned; 0xFF is accepted next cycle; count = 16.
- Fill to 15, then push and pop simultaneously for 40 cycles -> count stays 15; data order is preserved across pointer wrap.
- Pulse rx_frame_error and status_clear together -> frame_flag = 1, irq = 1. Assert status_clear alone -> flag = 0. Without the macro, irq = 0 only if the FIFO is empty.
- Hold 5 bytes, then assert flush together with a push of 0x55 -> count = 0; tvalid = 0; 0x55 is dropped.
- With UART_RX_FIFO_THRESH_EN and threshold = 4: push 3 bytes -> irq = 0; push a 4th -> irq = 1 one edge later; pop one -> irq = 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: default byte width and status register bit layout.
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;

  // Bit positions of the sticky flags in the CPU-visible status word.
  localparam int UART_STAT_OVERRUN_BIT = 0;
  localparam int UART_STAT_FRAME_BIT   = 1;
  localparam int UART_STAT_WIDTH       = 2;

endpackage

// File: rtl/uart_rx_fifo_ram.sv
// Simple dual-port storage for the receive FIFO: synchronous write port,
// asynchronous read port so the head entry falls through without latency.
// Contents are intentionally not reset.
module uart_rx_fifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  // Write the incoming byte into the addressed slot.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT byte FIFO between the UART receiver and the CPU
// register interface. Captures receiver error pulses as sticky flags and
// raises a registered interrupt.
// Optional feature macro: UART_RX_FIFO_THRESH_EN -- when defined the data
// part of the interrupt fires at an occupancy threshold instead of on
// "not empty"; the port list is the same either way.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] input_axis_tdata,
  input  logic                  input_axis_tvalid,
  output logic                  input_axis_tready,
  output logic [DATA_WIDTH-1:0] output_axis_tdata,
  output logic                  output_axis_tvalid,
  input  logic                  output_axis_tready,
  input  logic                  rx_overrun_error,
  input  logic                  rx_frame_error,
  input  logic                  flush,
  input  logic                  status_clear,
  input  logic [ADDR_WIDTH:0]   threshold,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overrun_flag,
  output logic                  frame_flag,
  output logic                  irq
);

  localparam logic [ADDR_WIDTH:0] PTR_ZERO = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH:0] PTR_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  // Pointers carry one extra MSB so full and empty are distinguishable.
  logic [ADDR_WIDTH:0] wr_ptr_r, rd_ptr_r;
  logic [ADDR_WIDTH:0] wr_ptr_next_s, rd_ptr_next_s;
  logic [ADDR_WIDTH:0] count_s, count_next_s;
  logic                empty_s, full_s, empty_next_s;
  logic                push_s, pop_s, wr_en_s;
  logic [UART_STAT_WIDTH-1:0] status_r, status_next_s;
  logic                data_term_s;
  logic                irq_r;

  assign empty_s = (wr_ptr_r == rd_ptr_r);
  assign full_s  = (wr_ptr_r[ADDR_WIDTH-1:0] == rd_ptr_r[ADDR_WIDTH-1:0]) &&
                   (wr_ptr_r[ADDR_WIDTH] != rd_ptr_r[ADDR_WIDTH]);
  assign count_s = wr_ptr_r - rd_ptr_r;

  assign push_s  = input_axis_tvalid && !full_s;
  assign pop_s   = !empty_s && output_axis_tready;
  // A flush discards any simultaneous push, so the array is not written.
  assign wr_en_s = push_s && !flush;

  // Next pointer values: flush returns to origin, otherwise advance per handshake.
  always_comb begin
    wr_ptr_next_s = wr_ptr_r;
    rd_ptr_next_s = rd_ptr_r;
    if (flush) begin
      wr_ptr_next_s = PTR_ZERO;
      rd_ptr_next_s = PTR_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_next_s = wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_next_s = wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_next_s = rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_next_s = rd_ptr_r;
      end
    end
  end

  assign count_next_s = wr_ptr_next_s - rd_ptr_next_s;
  assign empty_next_s = (wr_ptr_next_s == rd_ptr_next_s);

  // Sticky flags: a new error pulse wins over a simultaneous clear.
  always_comb begin
    status_next_s = status_r;
    if (status_clear) begin
      status_next_s = {UART_STAT_WIDTH{1'b0}};
    end else begin
      status_next_s = status_r;
    end
    if (rx_overrun_error) begin
      status_next_s[UART_STAT_OVERRUN_BIT] = 1'b1;
    end else begin
      status_next_s[UART_STAT_OVERRUN_BIT] = status_next_s[UART_STAT_OVERRUN_BIT];
    end
    if (rx_frame_error) begin
      status_next_s[UART_STAT_FRAME_BIT] = 1'b1;
    end else begin
      status_next_s[UART_STAT_FRAME_BIT] = status_next_s[UART_STAT_FRAME_BIT];
    end
  end

`ifdef UART_RX_FIFO_THRESH_EN
  assign data_term_s = (count_next_s >= threshold) && (threshold != PTR_ZERO);
`else
  // Threshold port exists for a uniform port list but has no effect here.
  logic threshold_unused_s;
  assign threshold_unused_s = ^threshold;
  assign data_term_s        = !empty_next_s;
`endif

  // Pointer, flag and interrupt state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      status_r <= {UART_STAT_WIDTH{1'b0}};
      irq_r    <= 1'b0;
    end else begin
      wr_ptr_r <= wr_ptr_next_s;
      rd_ptr_r <= rd_ptr_next_s;
      status_r <= status_next_s;
      irq_r    <= status_next_s[UART_STAT_OVERRUN_BIT] ||
                  status_next_s[UART_STAT_FRAME_BIT] || data_term_s;
    end
  end

  uart_rx_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en_s),
    .wr_addr (wr_ptr_r[ADDR_WIDTH-1:0]),
    .wr_data (input_axis_tdata),
    .rd_addr (rd_ptr_r[ADDR_WIDTH-1:0]),
    .rd_data (output_axis_tdata)
  );

  assign input_axis_tready  = !full_s;
  assign output_axis_tvalid = !empty_s;
  assign count              = count_s;
  assign overrun_flag       = status_r[UART_STAT_OVERRUN_BIT];
  assign frame_flag         = status_r[UART_STAT_FRAME_BIT];
  assign irq                = irq_r;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: a table of single-cycle vectors
// followed by hand-written sequences for full, wrap, flush and reset cases.
module tb_uart_rx_fifo;

  logic       clk;
  logic       rst;
  logic [7:0] input_axis_tdata;
  logic       input_axis_tvalid;
  logic       input_axis_tready;
  logic [7:0] output_axis_tdata;
  logic       output_axis_tvalid;
  logic       output_axis_tready;
  logic       rx_overrun_error;
  logic       rx_frame_error;
  logic       flush;
  logic       status_clear;
  logic [4:0] threshold;
  logic [4:0] count;
  logic       overrun_flag;
  logic       frame_flag;
  logic       irq;

  int tests_run;
  int tests_failed;

  uart_rx_fifo dut (
    .clk                (clk),
    .rst                (rst),
    .input_axis_tdata   (input_axis_tdata),
    .input_axis_tvalid  (input_axis_tvalid),
    .input_axis_tready  (input_axis_tready),
    .output_axis_tdata  (output_axis_tdata),
    .output_axis_tvalid (output_axis_tvalid),
    .output_axis_tready (output_axis_tready),
    .rx_overrun_error   (rx_overrun_error),
    .rx_frame_error     (rx_frame_error),
    .flush              (flush),
    .status_clear       (status_clear),
    .threshold          (threshold),
    .count              (count),
    .overrun_flag       (overrun_flag),
    .frame_flag         (frame_flag),
    .irq                (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;
    logic       ovr;
    logic       frm;
    logic       fl;
    logic       sclr;
    logic [4:0] exp_count;
    logic       exp_valid;
    logic [7:0] exp_head;
    logic       exp_ovf;
    logic       exp_frf;
  } vec_t;

  vec_t vecs [15];
  logic [7:0] q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected interrupt level after an edge, from the resulting state.
  function automatic logic exp_irq(input logic ovf, input logic frf, input logic [4:0] cnt);
    logic data_term;
`ifdef UART_RX_FIFO_THRESH_EN
    data_term = (cnt >= threshold) && (threshold != 5'd0);
`else
    data_term = (cnt != 5'd0);
`endif
    return ovf || frf || data_term;
  endfunction

  task automatic step(input logic iv, input logic [7:0] id, input logic ordy,
                      input logic ovr, input logic frm, input logic fl, input logic sc);
    input_axis_tvalid  = iv;
    input_axis_tdata   = id;
    output_axis_tready = ordy;
    rx_overrun_error   = ovr;
    rx_frame_error     = frm;
    flush              = fl;
    status_clear       = sc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst = 1'b1;
    threshold = 5'd4;
    input_axis_tvalid = 1'b0; input_axis_tdata = 8'h00; output_axis_tready = 1'b0;
    rx_overrun_error = 1'b0; rx_frame_error = 1'b0; flush = 1'b0; status_clear = 1'b0;

    //               iv   data   ordy  ovr   frm   fl    sclr  cnt   vld   head   ovf   frf
    vecs[0]  = '{1'b1, 8'h41, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 1'b1, 8'h41, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 8'h42, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2, 1'b1, 8'h41, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 8'h43, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3, 1'b1, 8'h41, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b1, 8'h41, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 1'b1, 8'h41, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd3, 1'b1, 8'h41, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 1'b1, 8'h41, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2, 1'b1, 8'h42, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 8'h44, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2, 1'b1, 8'h43, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 8'h00, 1'b0, 1'b0};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_count",  32'(count), 32'd0);
    chk("rst_ovalid", 32'(output_axis_tvalid), 32'd0);
    chk("rst_itready", 32'(input_axis_tready), 32'd1);
    chk("rst_flags",  32'({overrun_flag, frame_flag}), 32'd0);
    chk("rst_irq",    32'(irq), 32'd0);
    @(posedge clk); #1;

    // Table-driven single-cycle vectors.
    for (int i = 0; i < 15; i++) begin
      step(vecs[i].in_valid, vecs[i].in_data, vecs[i].out_ready, vecs[i].ovr,
           vecs[i].frm, vecs[i].fl, vecs[i].sclr);
      chk($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
      chk($sformatf("v%0d_ovalid", i), 32'(output_axis_tvalid), 32'(vecs[i].exp_valid));
      chk($sformatf("v%0d_itready", i), 32'(input_axis_tready), 32'(vecs[i].exp_count != 5'd16));
      if (vecs[i].exp_valid) chk($sformatf("v%0d_head", i), 32'(output_axis_tdata), 32'(vecs[i].exp_head));
      chk($sformatf("v%0d_ovf", i), 32'(overrun_flag), 32'(vecs[i].exp_ovf));
      chk($sformatf("v%0d_frf", i), 32'(frame_flag), 32'(vecs[i].exp_frf));
      chk($sformatf("v%0d_irq", i), 32'(irq),
          32'(exp_irq(vecs[i].exp_ovf, vecs[i].exp_frf, vecs[i].exp_count)));
    end

    // Fill to full, hold off a 17th byte, pop one and let it in.
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("full_count", 32'(count), 32'd16);
    chk("full_itready", 32'(input_axis_tready), 32'd0);
    step(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("held_count", 32'(count), 32'd16);
    chk("held_head", 32'(output_axis_tdata), 32'h00);
    step(1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("popfull_count", 32'(count), 32'd15);
    chk("popfull_head", 32'(output_axis_tdata), 32'h01);
    chk("popfull_itready", 32'(input_axis_tready), 32'd1);
    step(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("refill_count", 32'(count), 32'd16);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain%0d", i), 32'(output_axis_tdata), (i < 15) ? 32'(i + 1) : 32'hFF);
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    chk("drained_count", 32'(count), 32'd0);
    chk("drained_ovalid", 32'(output_axis_tvalid), 32'd0);

    // Fill to 15 then stream push+pop across several pointer wraps.
    for (int i = 0; i < 15; i++) begin
      step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      q.push_back(8'(8'h80 + i));
    end
    chk("wrap_fill", 32'(count), 32'd15);
    for (int i = 0; i < 40; i++) begin
      chk($sformatf("wrap_head%0d", i), 32'(output_axis_tdata), 32'(q[0]));
      step(1'b1, 8'(8'hA0 + i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      void'(q.pop_front());
      q.push_back(8'(8'hA0 + i));
      chk($sformatf("wrap_count%0d", i), 32'(count), 32'd15);
    end
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("wrap_tail%0d", i), 32'(output_axis_tdata), 32'(q.pop_front()));
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Flush with 5 held bytes and a simultaneous push.
    chk("preflush_count", 32'(count), 32'd5);
    step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_ovalid", 32'(output_axis_tvalid), 32'd0);
    step(1'b1, 8'h66, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("postflush_head", 32'(output_axis_tdata), 32'h66);
    chk("postflush_count", 32'(count), 32'd1);

    // Asynchronous reset between edges with data and a flag present.
    step(1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("prerst_frf", 32'(frame_flag), 32'd1);
    input_axis_tvalid = 1'b0; rx_frame_error = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_ovalid", 32'(output_axis_tvalid), 32'd0);
    chk("arst_frf", 32'(frame_flag), 32'd0);
    chk("arst_irq", 32'(irq), 32'd0);
    #1 rst = 1'b0;
    idle();

`ifdef UART_RX_FIFO_THRESH_EN
    // Threshold interrupt at 4 entries.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("thr_below%0d", i), 32'(irq), 32'd0);
    end
    step(1'b1, 8'h13, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("thr_hit", 32'(irq), 32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("thr_pop", 32'(irq), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
